// File: rtl/msk_sched_pkg.sv
// ---------------------------------------------------------------------------
// msk_sched_pkg : shared encodings and sizing helpers for the masked XOR scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef MSK_SCHED_K
`define MSK_SCHED_K(n, c) ((n) / (c))
`endif

`ifndef MSK_SCHED_CNT_W
`define MSK_SCHED_CNT_W(k) (((k) <= 1) ? 1 : $clog2(k))
`endif

package msk_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit i of share j lives at i*d+j in every shared bus.
  function automatic int unsigned share_idx(input int unsigned i,
                                            input int unsigned j,
                                            input int unsigned d);
    return i * d + j;
  endfunction

endpackage

`default_nettype wire

// File: rtl/MSKxor_par.sv
// ---------------------------------------------------------------------------
// MSKxor_par : parallel affine masked XOR, share j of a only meets share j of b
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module MSKxor_par
  import msk_sched_pkg::*;
#(
  parameter int d     = 2,
  parameter int count = 1
) (
  input  logic [count*d-1:0] ina,
  input  logic [count*d-1:0] inb,
  output logic [count*d-1:0] out
);

  for (genvar i = 0; i < count; i++) begin : g_bit
    for (genvar j = 0; j < d; j++) begin : g_share
      localparam int unsigned IDX = share_idx(i, j, d);
      assign out[IDX] = ina[IDX] ^ inb[IDX];
    end
  end

endmodule

`default_nettype wire

// File: rtl/msk_xor_sched.sv
// ---------------------------------------------------------------------------
// msk_xor_sched : streams two d-share N-bit operands CHUNK bits/cycle through
// one masked XOR lane bank. Optional: MSK_XOR_SCHED_ZEROIZE_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module msk_xor_sched
  import msk_sched_pkg::*;
#(
  parameter int D     = 2,
  parameter int N     = 128,
  parameter int CHUNK = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*D-1:0] ina,
  input  logic [N*D-1:0] inb,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*D-1:0] out,
  output logic           busy
);

  localparam int K  = `MSK_SCHED_K(N, CHUNK);
  localparam int CW = `MSK_SCHED_CNT_W(K);
  localparam int W  = N * D;
  localparam int LW = CHUNK * D;
  localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

  if ((N % CHUNK) != 0) begin : g_bad_chunk
    $error("msk_xor_sched: N must be a multiple of CHUNK");
  end

  state_e          state_q, state_d;
  logic [W-1:0]    sa_q, sa_d;
  logic [W-1:0]    sb_q, sb_d;
  logic [W-1:0]    r_q, r_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]   lane_out;
  logic [W-1:0]    r_shifted;

  MSKxor_par #(
    .d     (D),
    .count (CHUNK)
  ) u_lane (
    .ina (sa_q[LW-1:0]),
    .inb (sb_q[LW-1:0]),
    .out (lane_out)
  );

  // New chunk enters at the top so chunk 0 lands at the bottom after K shifts.
  if (K == 1) begin : g_r_single
    assign r_shifted = lane_out;
  end else begin : g_r_multi
    assign r_shifted = {lane_out, r_q[W-1:LW]};
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);

`ifdef MSK_XOR_SCHED_ZEROIZE_EN
  assign out = out_valid ? r_q : '0;
`else
  assign out = r_q;
`endif

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d    = ina;
          sb_d    = inb;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sa_d = sa_q >> LW;
        sb_d = sb_q >> LW;
        r_d  = r_shifted;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef MSK_XOR_SCHED_ZEROIZE_EN
          r_d     = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_msk_xor_sched.sv
// ---------------------------------------------------------------------------
// tb_msk_xor_sched : directed scoreboard bench for msk_xor_sched (K=4 and K=1)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_msk_xor_sched;

  localparam int D = 2;
  localparam int N = 128;
  localparam int W = N * D;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [W-1:0] ina, inb, out, out1;

  msk_xor_sched #(.D(D), .N(N), .CHUNK(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ina(ina), .inb(inb), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .busy(busy)
  );

  msk_xor_sched #(.D(D), .N(N), .CHUNK(128)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .ina(ina), .inb(inb), .out_valid(out_valid1), .out_ready(out_ready1),
    .out(out1), .busy(busy1)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] expv, held, last;

  function automatic logic [W-1:0] pack2(input logic [N-1:0] s0, input logic [N-1:0] s1);
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) begin
      v[i*D]   = s0[i];
      v[i*D+1] = s1[i];
    end
    return v;
  endfunction

  function automatic logic [N-1:0] share(input logic [W-1:0] v, input int j);
    logic [N-1:0] s;
    for (int i = 0; i < N; i++) s[i] = v[i*D+j];
    return s;
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    return pack2(share(a, 0) ^ share(b, 0), share(a, 1) ^ share(b, 1));
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [N-1:0] a0, a1, b0, b1;
  int acc, outs, first_c, second_c;
  bit changed;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_valid1 = 1'b0;
    out_ready = 1'b0; out_ready1 = 1'b0; ina = '0; inb = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", W'(in_ready), W'(0));
    check("rst_in_ready1", W'(in_ready1), W'(0));
    rst = 1'b0;
    #1;
    check("reset_in_ready", W'(in_ready), W'(1));
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_busy", W'(busy), W'(0));
    check("reset_out", out, '0);

    // Test 1: basic K=4 operation
    @(negedge clk);
    a0 = '1; a1 = {16{8'h0F}};
    b0 = 128'h123456789ABCDEF0_0FEDCBA987654321; b1 = '0;
    ina = pack2(a0, a1); inb = pack2(b0, b1); in_valid = 1'b1;
    exp_q.push_back(model(ina, inb));
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t1_run_out_valid", W'(out_valid), W'(0));
      check("t1_run_in_ready", W'(in_ready), W'(0));
      @(negedge clk);
    end
    check("t1_out_valid", W'(out_valid), W'(1));
    expv = exp_q.pop_front();
    check("t1_out", out, expv);
    check("t1_recombined", W'(share(out, 0) ^ share(out, 1)), W'((a0 ^ a1) ^ (b0 ^ b1)));
    check("t1_share0", W'(share(out, 0)), W'(a0 ^ b0));
    check("t1_share1", W'(share(out, 1)), W'(a1 ^ b1));

    // Test 2: stall in DONE, stray in_valid pulses ignored
    held = expv;
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      ina = ~ina;
      @(negedge clk);
      check("t2_out_valid", W'(out_valid), W'(1));
      check("t2_out", out, held);
      check("t2_busy", W'(busy), W'(1));
      check("t2_in_ready", W'(in_ready), W'(0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t2_post_out_valid", W'(out_valid), W'(0));
    check("t2_post_in_ready", W'(in_ready), W'(1));
`ifdef MSK_XOR_SCHED_ZEROIZE_EN
    check("t6_out_zeroized", out, '0);
`else
    check("t6_out_retained", out, held);
`endif

    // Test 3: back-to-back issue
    a0 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D; a1 = 128'h5555_AAAA_3333_CCCC_0F0F_F0F0_1111_EEEE;
    b0 = 128'hFEDCBA98_76543210_0BADC0DE_A5A5A5A5; b1 = 128'h0123_4567_89AB_CDEF_FFFF_0000_8888_7777;
    ina = pack2(a0, a1); inb = pack2(b0, b1);
    in_valid = 1'b1; out_ready = 1'b1;
    acc = 0; outs = 0; first_c = 0; second_c = 0; changed = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (acc == 1 && !changed) begin
        ina = pack2(a1, b0); inb = pack2(b1, a0); changed = 1'b1;
      end
      if (acc == 2) in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("t3_unexpected_out", W'(1), W'(0));
        else check("t3_out", out, exp_q.pop_front());
        outs++;
      end
      if (in_valid && in_ready) begin
        if (acc == 0) first_c = cyc; else second_c = cyc;
        exp_q.push_back(model(ina, inb));
        acc++;
      end
      if (acc == 2 && outs == 2) break;
      @(negedge clk);
    end
    check("t3_accepts", W'(acc), W'(2));
    check("t3_outputs", W'(outs), W'(2));
    check("t3_issue_interval", W'(second_c - first_c), W'(6));
    @(negedge clk);
    out_ready = 1'b0;

    // Test 4: reset during RUN aborts the operation
    ina = pack2(a0, b1); inb = pack2(a1, b0); in_valid = 1'b1;
    exp_q.push_back(model(ina, inb));
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t4_rst_in_ready", W'(in_ready), W'(0));
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("t4_in_ready", W'(in_ready), W'(1));
    check("t4_out", out, '0);
    check("t4_busy", W'(busy), W'(0));
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t4_no_out_valid", W'(out_valid), W'(0));
    end
    out_ready = 1'b0;

    // Test 5: K=1 instance
    @(negedge clk);
    ina = pack2(a0, a1); inb = pack2(b0, b1); in_valid1 = 1'b1;
    last = model(ina, inb);
    @(negedge clk);
    in_valid1 = 1'b0;
    #1;
    check("t5_run_out_valid", W'(out_valid1), W'(0));
    check("t5_run_busy", W'(busy1), W'(1));
    @(negedge clk);
    check("t5_out_valid", W'(out_valid1), W'(1));
    check("t5_out", out1, last);
    check("t5_in_ready", W'(in_ready1), W'(0));
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    check("t5_post_out_valid", W'(out_valid1), W'(0));
    check("t5_post_in_ready", W'(in_ready1), W'(1));
`ifdef MSK_XOR_SCHED_ZEROIZE_EN
    check("t6_k1_out_zeroized", out1, '0);
`else
    check("t6_k1_out_retained", out1, last);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
